// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional WAIT-state watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          done_pulse,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done,
  output logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  // state | meaning
  // IDLE  | offering req_ready to the round-robin winner
  // START | tx_start pulse, byte latched on tx_data
  // WAIT  | frame in progress, watching tx_done
  // DONE  | done_pulse to owner, pointer moves to owner
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  if ((NUM_REQ < 2) || (NUM_REQ > 16) || (TIMEOUT_CYC < 2)) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [GW-1:0]     winner;
  logic              found;
  int unsigned       idx;
  logic              expire;

  // Search starts just after the last owner so it becomes lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          data_d  = req_data[winner*DATA_W +: DATA_W];
          grant_d = winner;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done || expire) state_d = DONE;
      end
      DONE: begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign expire = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // tx_done takes precedence over a simultaneous expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == START) cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + 1'b1;
    err_d = expire && !tx_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign req_ready  = ((state_q == IDLE) && found) ? (NUM_REQ'(1) << winner) : '0;
  assign done_pulse = (state_q == DONE) ? (NUM_REQ'(1) << grant_q) : '0;
  assign tx_start   = (state_q == START);
  assign tx_busy    = (state_q != IDLE);
  assign tx_data    = data_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// against a timestamp-based transaction model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TO  = 16;
  localparam int INF = 32'h7fff_ffff;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            tx_done = 1'b0;
  logic [N-1:0]    req_ready, done_pulse;
  logic            tx_start, tx_busy, timeout_err;
  logic [DW-1:0]   tx_data;
  logic [1:0]      grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .done_pulse(done_pulse), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .tx_busy(tx_busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction model: one byte in flight, described by its start and done cycles.
  int            cyc = 0;
  bit            m_have = 0;
  int            m_start = 0;
  int            m_done = 0;
  int            m_owner = 0;
  int            m_ptr = N - 1;
  logic [DW-1:0] m_data = '0;
  bit            m_err = 0;

  logic [N-1:0]  s_ready, s_done;
  logic          s_start, s_busy, s_err;
  logic [DW-1:0] s_data;
  logic [1:0]    s_grant;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    m_have = 0; m_ptr = N - 1; m_owner = 0; m_data = '0; m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; tx_done = 1'b0;
    #1;
    chk("rst_busy", tx_busy, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_data", tx_data, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic dn);
    logic [N-1:0] e_ready;
    int w;
    bit idle;
    @(negedge clk);
    req_valid = v; req_data = d; tx_done = dn;
    #1;
    s_ready = req_ready; s_done = done_pulse; s_start = tx_start; s_busy = tx_busy;
    s_err = timeout_err; s_data = tx_data; s_grant = grant_id;
    idle = !m_have || (cyc > m_done);
    e_ready = '0;
    w = -1;
    if (idle) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (w < 0 && v[k]) w = k;
      end
    end
    if (w >= 0) e_ready[w] = 1'b1;
    chk("req_ready", s_ready, e_ready);
    chk("tx_start", s_start, m_have && cyc == m_start);
    chk("tx_busy", s_busy, m_have && cyc >= m_start && cyc <= m_done);
    chk("done_pulse", s_done, (m_have && cyc == m_done) ? (1 << m_owner) : 0);
    chk("timeout_err", s_err, m_have && cyc == m_done && m_err);
    chk("grant_id", s_grant, m_owner);
    chk("tx_data", s_data, m_data);
    if (w >= 0) begin
      m_have = 1; m_owner = w; m_data = d[w*DW +: DW];
      m_start = cyc + 1; m_done = INF; m_err = 0;
    end else if (m_have && m_done == INF && cyc > m_start) begin
      if (dn) begin
        m_done = cyc + 1; m_ptr = m_owner;
      end
`ifdef UART_TX_ARB_TIMEOUT_EN
      else if (cyc - m_start - 1 == TO - 1) begin
        m_done = cyc + 1; m_err = 1; m_ptr = m_owner;
      end
`endif
    end
    cyc++;
  endtask

  // One full transaction: accept, start, tx_done wait_n cycles after start, done pulse.
  task automatic txn(input logic [N-1:0] v, input int wait_n, input bit spur, output logic [N-1:0] rdy);
    step(v, rnd_data(), spur);
    rdy = s_ready;
    step(v, rnd_data(), spur);
    for (int i = 1; i < wait_n; i++) step(v, rnd_data(), 1'b0);
    step(v, rnd_data(), 1'b1);
    step(v, rnd_data(), 1'b0);
  endtask

  initial begin
    logic [N*DW-1:0] d;
    logic [N-1:0]    r;
    logic [N-1:0]    v;
    logic            dn;
    int              order[5] = '{0, 1, 2, 3, 0};

    do_reset();

    // Single request from requester 2
    d = rnd_data();
    d[23:16] = 8'hA5;
    step(4'b0100, d, 1'b0);
    chk("t1_ready", s_ready, 4'b0100);
    step(4'b0000, rnd_data(), 1'b0);
    chk("t1_start", s_start, 1);
    chk("t1_data", s_data, 8'hA5);
    for (int i = 1; i < 10; i++) step(4'b0000, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b0);
    chk("t1_done", s_done, 4'b0100);
    step(4'b0000, rnd_data(), 1'b0);
    chk("t1_idle", s_busy, 0);

    // Round-robin with every requester valid
    do_reset();
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, 5, 1'b0, r);
      chk("rr_grant", r, 1 << order[k]);
      chk("rr_done", s_done, 1 << order[k]);
    end

    // Skipping idle requesters; last owner is 0
    txn(4'b0010, 3, 1'b0, r);
    chk("skip_a", r, 4'b0010);
    txn(4'b0011, 3, 1'b0, r);
    chk("skip_b", r, 4'b0001);
    txn(4'b0011, 3, 1'b0, r);
    chk("skip_c", r, 4'b0010);

    // Spurious tx_done in IDLE and START is ignored
    txn(4'b1000, 3, 1'b1, r);
    chk("spur_grant", r, 4'b1000);

    // Reset in the middle of WAIT
    step(4'b0100, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b0);
    do_reset();
    step(4'b1111, rnd_data(), 1'b0);
    chk("rst_next_grant", s_ready, 4'b0001);
    step(4'b0000, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b0);
    chk("rst_next_done", s_done, 4'b0001);
    step(4'b0000, rnd_data(), 1'b0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    step(4'b0001, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b0);
    for (int i = 0; i < TO; i++) step(4'b0000, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b0);
    chk("to_done", s_done, 4'b0001);
    chk("to_err", s_err, 1);
    step(4'b0000, rnd_data(), 1'b0);
    step(4'b0001, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b0);
    for (int i = 0; i < TO - 1; i++) step(4'b0000, rnd_data(), 1'b0);
    step(4'b0000, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b0);
    chk("to_race_done", s_done, 4'b0001);
    chk("to_race_err", s_err, 0);
    step(4'b0000, rnd_data(), 1'b0);
`endif

    // Randomized traffic with alternating fast and slow transmitter phases
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if (((c / 500) % 2) == 1) dn = ($urandom_range(0, 39) == 0);
        else dn = ($urandom_range(0, 3) == 0);
        v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
        step(v, rnd_data(), dn);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
